nf_hex_display_ctrl: RTL and testbench

Sequential controller that drives the board's six-digit static seven-segment datapath. It accepts a binary value over a valid/ready handshake and converts it to six BCD digits with an iterative shift-add-3 (double-dabble) FSM. It registers the digits together with a per-digit enable mask, and flags out-of-range values. It sits between the core/board glue and `nf_seven_seg_static`, replacing a hard-wired constant on the display input.

---
 rtl/nf_hex_display_ctrl_pkg.sv | 32 +++
 rtl/nf_hex_display_ctrl_if.sv | 27 ++
 rtl/nf_hex_display_ctrl_bcd_adj.sv | 9 +
 rtl/nf_hex_display_ctrl.sv | 142 ++++++++++++++
 tb/tb_nf_hex_display_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/nf_hex_display_ctrl_pkg.sv
// Shared types and constants for the six-digit hex/BCD display controller.
// Optional leading-zero blanking helper is used when NF_HEX_LZB_EN is defined.
package nf_hex_pkg;

  localparam int unsigned NF_HEX_DIGITS  = 6;
  localparam int unsigned NF_HEX_BIN_W   = 20;
  localparam int unsigned NF_HEX_MAX     = 999999;
  localparam logic [3:0]  NF_HEX_OVF_NIB = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } nf_hex_st_e;

  // Enable every digit at or below the most significant non-zero digit; digit 0 always on.
  function automatic logic [NF_HEX_DIGITS-1:0] nf_hex_lzb_mask(
    input logic [4*NF_HEX_DIGITS-1:0] d
  );
    logic                     seen;
    logic [NF_HEX_DIGITS-1:0] mask;
    seen = 1'b0;
    mask = '0;
    for (int i = NF_HEX_DIGITS - 1; i >= 0; i--) begin
      seen    = seen | (d[4*i +: 4] != 4'h0);
      mask[i] = seen;
    end
    mask[0] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/nf_hex_display_ctrl_if.sv
// Value-in / display-out bundle between the board glue (master) and the controller (slave).
interface nf_hex_display_ctrl_if
  import nf_hex_pkg::*;
#(
  parameter int unsigned DIGITS = NF_HEX_DIGITS,
  parameter int unsigned BIN_W  = NF_HEX_BIN_W
);

  logic [BIN_W-1:0]    bin;
  logic                bin_vld;
  logic                bin_rdy;
  logic [4*DIGITS-1:0] digits;
  logic [DIGITS-1:0]   dig_en;
  logic                ovf;
  logic                upd;

  modport master (
    output bin, bin_vld,
    input  bin_rdy, digits, dig_en, ovf, upd
  );

  modport slave (
    input  bin, bin_vld,
    output bin_rdy, digits, dig_en, ovf, upd
  );

endinterface

// File: rtl/nf_hex_display_ctrl_bcd_adj.sv
// Double-dabble digit correction: add 3 to any BCD nibble of 5 or more before the shift.
module nf_bcd_adj (
  input  logic [3:0] nib,
  output logic [3:0] nib_adj_c
);

  assign nib_adj_c = (nib >= 4'd5) ? 4'(nib + 4'd3) : nib;

endmodule

// File: rtl/nf_hex_display_ctrl.sv
// Binary-to-BCD display controller: shift-add-3 FSM feeding registered digits, enables and overflow.
// Define NF_HEX_LZB_EN to blank leading zero digits via dig_en.
module nf_hex_display_ctrl
  import nf_hex_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  nf_hex_display_ctrl_if.slave  dsp
);

  localparam int unsigned DIGITS = NF_HEX_DIGITS;
  localparam int unsigned BIN_W  = NF_HEX_BIN_W;
  localparam int unsigned ACC_W  = 4 * DIGITS;
  localparam int unsigned CNT_W  = $clog2(BIN_W);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_CONV = CONV;
  localparam logic [1:0] S_DONE = DONE;

`ifdef NF_HEX_LZB_EN
  localparam logic [DIGITS-1:0] DIG_EN_RST = DIGITS'(1);
`else
  localparam logic [DIGITS-1:0] DIG_EN_RST = '1;
`endif

  logic [1:0]        state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [BIN_W-1:0]  sh_q,       sh_d;
  logic [ACC_W-1:0]  acc_q,      acc_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic [ACC_W-1:0]  digits_q,   digits_d;
  logic [DIGITS-1:0] dig_en_q,   dig_en_d;
  logic              ovf_q,      ovf_d;
  logic              upd_q,      upd_d;
  logic              rdy_q,      rdy_d;

  logic [ACC_W-1:0]  acc_adj;
  logic              acc_msb_unused;

  // Per-digit add-3 correction applied before each shift
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    nf_bcd_adj u_adj (
      .nib       (acc_q[4*g +: 4]),
      .nib_adj_c (acc_adj[4*g +: 4])
    );
  end

  // In-range values never carry into the top accumulator bit, so it is dropped by the shift
  assign acc_msb_unused = acc_adj[ACC_W-1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      acc_q      <= '0;
      ovf_pend_q <= 1'b0;
      digits_q   <= '0;
      dig_en_q   <= DIG_EN_RST;
      ovf_q      <= 1'b0;
      upd_q      <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      acc_q      <= acc_d;
      ovf_pend_q <= ovf_pend_d;
      digits_q   <= digits_d;
      dig_en_q   <= dig_en_d;
      ovf_q      <= ovf_d;
      upd_q      <= upd_d;
      rdy_q      <= rdy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    acc_d      = acc_q;
    ovf_pend_d = ovf_pend_q;
    digits_d   = digits_q;
    dig_en_d   = dig_en_q;
    ovf_d      = ovf_q;
    upd_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (dsp.bin_vld && rdy_q) begin
          if (dsp.bin > BIN_W'(NF_HEX_MAX)) begin
            ovf_pend_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            sh_d       = dsp.bin;
            acc_d      = '0;
            cnt_d      = CNT_W'(BIN_W - 1);
            ovf_pend_d = 1'b0;
            state_d    = S_CONV;
          end
        end
      end
      S_CONV: begin
        acc_d = {acc_adj[ACC_W-2:0], sh_q[BIN_W-1]};
        sh_d  = {sh_q[BIN_W-2:0], 1'b0};
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = CNT_W'(cnt_q - 1'b1);
        end
      end
      S_DONE: begin
        upd_d   = 1'b1;
        state_d = S_IDLE;
        if (ovf_pend_q) begin
          digits_d = {DIGITS{NF_HEX_OVF_NIB}};
          ovf_d    = 1'b1;
`ifdef NF_HEX_LZB_EN
          dig_en_d = '1;
`endif
        end else begin
          digits_d = acc_q;
          ovf_d    = 1'b0;
`ifdef NF_HEX_LZB_EN
          dig_en_d = nf_hex_lzb_mask(acc_q);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Ready is registered from the next state so bin_vld never reaches bin_rdy combinationally
    rdy_d = (state_d == S_IDLE);
  end

  assign dsp.bin_rdy = rdy_q;
  assign dsp.digits  = digits_q;
  assign dsp.dig_en  = dig_en_q;
  assign dsp.ovf     = ovf_q;
  assign dsp.upd     = upd_q;

endmodule

// File: tb/tb_nf_hex_display_ctrl.sv
// Scoreboard bench for nf_hex_display_ctrl; expectations follow NF_HEX_LZB_EN when defined.
module tb_nf_hex_display_ctrl;
  import nf_hex_pkg::*;

  localparam int unsigned DW       = 4 * NF_HEX_DIGITS;
  localparam int unsigned LAT_CONV = 21;
  localparam int unsigned LAT_OVF  = 1;
  localparam int          NVEC     = 8;

`ifdef NF_HEX_LZB_EN
  localparam logic [5:0] EN_RST = 6'b000001;
`else
  localparam logic [5:0] EN_RST = 6'b111111;
`endif

  typedef struct packed {
    logic [DW-1:0] digits;
    logic [5:0]    en;
    logic          ovf;
    logic [31:0]   cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        sb[$];

  nf_hex_display_ctrl_if dif ();

  nf_hex_display_ctrl u_dut (
    .clk    (clk),
    .resetn (resetn),
    .dsp    (dif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Directed vectors: value, BCD digits, leading-zero-blanked enable mask, overflow
  int unsigned vec_val [NVEC] = '{2019, 0, 999999, 1000000, 5, 100000, 10, 1048575};
  logic [23:0] vec_dig [NVEC] = '{24'h002019, 24'h000000, 24'h999999, 24'hFFFFFF,
                                  24'h000005, 24'h100000, 24'h000010, 24'hFFFFFF};
  logic [5:0]  vec_lzb [NVEC] = '{6'b001111, 6'b000001, 6'b111111, 6'b111111,
                                  6'b000001, 6'b111111, 6'b000011, 6'b111111};
  logic        vec_ovf [NVEC] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  function automatic logic [5:0] exp_en(input logic [5:0] lzb);
`ifdef NF_HEX_LZB_EN
    return lzb;
`else
    return (lzb | 6'b111111);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [NF_HEX_BIN_W-1:0] v, input logic [23:0] d,
                      input logic [5:0] en, input logic o, input bit push);
    int   w;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (!dif.bin_rdy && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!dif.bin_rdy) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_rdy_timeout: bin_rdy stayed %0b, required 1", dif.bin_rdy);
      return;
    end
    dif.bin     = v;
    dif.bin_vld = 1'b1;
    if (push) begin
      e.digits = d;
      e.en     = exp_en(en);
      e.ovf    = o;
      e.cyc    = cyc + 1 + (o ? LAT_OVF : LAT_CONV);
      sb.push_back(e);
    end
    @(negedge clk);
    dif.bin_vld = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d updates pending, required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: pop and compare on every upd, check upd width and output hold between updates
  logic [DW-1:0] prev_dig;
  logic [5:0]    prev_en;
  logic          prev_ovf;
  logic          prev_upd  = 1'b0;
  logic          prev_rstn = 1'b0;
  exp_t          got;

  always @(negedge clk) begin
    if (resetn) begin
      if (prev_upd) check("upd_width", 32'(dif.upd), 32'd0);
      if (dif.upd) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_upd: upd=1 digits=%0h, required no update", dif.digits);
        end else begin
          got = sb.pop_front();
          check("digits", 32'(dif.digits), 32'(got.digits));
          check("dig_en", 32'(dif.dig_en), 32'(got.en));
          check("ovf", 32'(dif.ovf), 32'(got.ovf));
          check("upd_cycle", cyc, got.cyc);
        end
      end else if (prev_rstn) begin
        check("hold_digits", 32'(dif.digits), 32'(prev_dig));
        check("hold_dig_en", 32'(dif.dig_en), 32'(prev_en));
        check("hold_ovf", 32'(dif.ovf), 32'(prev_ovf));
      end
    end
    prev_dig  = dif.digits;
    prev_en   = dif.dig_en;
    prev_ovf  = dif.ovf;
    prev_upd  = dif.upd;
    prev_rstn = resetn;
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_bin_rdy"}, 32'(dif.bin_rdy), 32'd1);
    check({tag, "_digits"}, 32'(dif.digits), 32'd0);
    check({tag, "_dig_en"}, 32'(dif.dig_en), 32'(EN_RST));
    check({tag, "_ovf"}, 32'(dif.ovf), 32'd0);
    check({tag, "_upd"}, 32'(dif.upd), 32'd0);
  endtask

  initial begin
    resetn      = 1'b0;
    dif.bin     = '0;
    dif.bin_vld = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    resetn = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      send(NF_HEX_BIN_W'(vec_val[i]), vec_dig[i], vec_lzb[i], vec_ovf[i], 1'b1);
      drain();
    end

    // Values offered during a conversion are dropped, not queued
    send(NF_HEX_BIN_W'(123456), 24'h123456, 6'b111111, 1'b0, 1'b1);
    for (int i = 0; i < 21; i++) begin
      dif.bin     = NF_HEX_BIN_W'(777);
      dif.bin_vld = (i < 20);
      check("busy_rdy_low", 32'(dif.bin_rdy), 32'd0);
      @(negedge clk);
    end
    dif.bin_vld = 1'b0;
    check("rdy_back", 32'(dif.bin_rdy), 32'd1);
    drain();
    repeat (5) @(negedge clk);

    // Reset in the middle of a conversion aborts it without an update
    send(NF_HEX_BIN_W'(654321), 24'h654321, 6'b111111, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    #2 resetn = 1'b0;
    #1 check_reset_vals("abort");
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("abort_rdy_after", 32'(dif.bin_rdy), 32'd1);
    repeat (30) @(negedge clk);

    send(NF_HEX_BIN_W'(42), 24'h000042, 6'b000011, 1'b0, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
